// File: rtl/debug_input_controller_pkg.sv
// debug_input_pkg: FSM state type plus KEY and SW field positions for the debug input controller
package debug_input_pkg;
  typedef enum logic [1:0] {IDLE, STEP, BURST, RUN} state_t;
  localparam int KEY_STEP = 0;
  localparam int KEY_BURST = 1;
  localparam int KEY_BP = 2;
  localparam int MANUAL_BIT = 9;
  localparam int SHOW_REG_BIT = 8;
  localparam int REG_SEL_HI = 7;
  localparam int REG_SEL_LO = 3;
  localparam int STAGE_HI = 2;
  localparam int STAGE_LO = 0;
endpackage

// File: rtl/debug_input_controller_if.sv
// debug_input_controller_if: raw board inputs and CPU debug controls; bp_hit exists only with DEBUG_INPUT_BREAKPOINT_EN
interface debug_input_controller_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] pc_fetch_unit;
  logic cpu_clk_en;
  logic manual_mode;
  logic show_reg_mode;
  logic [4:0] reg_sel;
  logic [2:0] stage_sel;
  logic sel_changed;
  logic busy;
`ifdef DEBUG_INPUT_BREAKPOINT_EN
  logic bp_hit;
  modport master (input KEY, SW, pc_fetch_unit, output cpu_clk_en, manual_mode, show_reg_mode, reg_sel, stage_sel, sel_changed, busy, bp_hit);
  modport slave (output KEY, SW, pc_fetch_unit, input cpu_clk_en, manual_mode, show_reg_mode, reg_sel, stage_sel, sel_changed, busy, bp_hit);
`else
  modport master (input KEY, SW, pc_fetch_unit, output cpu_clk_en, manual_mode, show_reg_mode, reg_sel, stage_sel, sel_changed, busy);
  modport slave (output KEY, SW, pc_fetch_unit, input cpu_clk_en, manual_mode, show_reg_mode, reg_sel, stage_sel, sel_changed, busy);
`endif
endinterface

// File: rtl/debug_input_controller_debounce_bit.sv
// debounce_bit: two-flop synchronizer plus stability-count debouncer for one input bit
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) sync <= {sync[0], d};
  always_ff @(posedge clk)
    if (rst || sync[1] == q || cnt == LAST) begin
      q <= sync[1];
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/debug_input_controller.sv
// debug_input_controller: debounced switch/key front end driving CPU step, burst and run enables; DEBUG_INPUT_BREAKPOINT_EN adds a fetch-PC breakpoint
module debug_input_controller
  import debug_input_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  BURST_LEN = 8'd16,
  parameter logic [7:0]  AUTO_DIV = 8'd1
) (
  input logic clk,
  input logic rst,
  debug_input_controller_if.master io
);
  localparam logic [7:0] DIV_LAST = (AUTO_DIV == 8'd0) ? 8'd0 : AUTO_DIV - 8'd1;
  logic [13:0] raw, db, db_q;
  logic [9:0] sw;
  logic [3:0] key, ev;
  state_t state, state_n;
  logic [7:0] burst_cnt, burst_n, div_cnt, div_n;
  logic bp_stop, halted, unused_ok;
  assign raw = {io.KEY, io.SW};
  for (genvar i = 0; i < 14; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(int'(DEBOUNCE_CYCLES))) u_db (.clk(clk), .rst(rst), .d(raw[i]), .q(db[i]));
  end
  assign sw = db[9:0];
  assign key = db[13:10];
  assign ev = db_q[13:10] & ~key;
  assign io.manual_mode = sw[MANUAL_BIT];
  assign io.show_reg_mode = sw[SHOW_REG_BIT];
  assign io.reg_sel = sw[REG_SEL_HI:REG_SEL_LO];
  assign io.stage_sel = sw[STAGE_HI:STAGE_LO];
  assign io.sel_changed = |(sw ^ db_q[9:0]);
  assign io.busy = state == STEP || state == BURST;
  always_ff @(posedge clk) db_q <= db;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      burst_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state <= state_n;
      burst_cnt <= burst_n;
      div_cnt <= div_n;
    end
  always_comb begin
    state_n = state;
    burst_n = burst_cnt;
    div_n = '0;
    io.cpu_clk_en = 1'b0;
    case (state)
      IDLE: begin
        if (!io.manual_mode && !halted) state_n = RUN;
        else if (ev[KEY_STEP]) state_n = STEP;
        else if (ev[KEY_BURST] && io.manual_mode) begin
          state_n = BURST;
          burst_n = BURST_LEN;
        end
      end
      STEP: begin
        io.cpu_clk_en = 1'b1;
        state_n = IDLE;
      end
      BURST: begin
        io.cpu_clk_en = 1'b1;
        burst_n = burst_cnt - 8'd1;
        state_n = (burst_cnt <= 8'd1) ? IDLE : BURST;
      end
      default: begin
        io.cpu_clk_en = div_cnt == 8'd0 && !bp_stop;
        div_n = (div_cnt >= DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
        state_n = (io.manual_mode || bp_stop) ? IDLE : RUN;
      end
    endcase
  end
`ifdef DEBUG_INPUT_BREAKPOINT_EN
  logic [6:0] bp_addr;
  logic bp_valid;
  assign bp_stop = state == RUN && div_cnt == 8'd0 && bp_valid && io.pc_fetch_unit == bp_addr;
  assign io.bp_hit = bp_stop;
  assign unused_ok = ev[3];
  always_ff @(posedge clk)
    if (rst) begin
      bp_valid <= 1'b0;
      bp_addr <= '0;
      halted <= 1'b0;
    end else begin
      if (ev[KEY_BP]) begin
        bp_valid <= 1'b1;
        bp_addr <= sw[6:0];
      end
      halted <= bp_stop || (halted && !io.manual_mode && !ev[KEY_STEP]);
    end
`else
  assign bp_stop = 1'b0;
  assign halted = 1'b0;
  assign unused_ok = ^{ev[3:2], io.pc_fetch_unit};
`endif
endmodule

// File: tb/tb_debug_input_controller.sv
// tb_debug_input_controller: scoreboard bench for reset, step, bounce, burst, run and the optional breakpoint
module tb_debug_input_controller;
  import debug_input_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  int exp_q[$];
  int sel_q[$];
  int hit_q[$];
  debug_input_controller_if dbg ();
  debug_input_controller #(.DEBOUNCE_CYCLES(16'd4), .BURST_LEN(8'd3), .AUTO_DIV(8'd2)) dut (.clk(clk), .rst(rst), .io(dbg));
  always #5 clk = ~clk;

  task automatic test_reset();
    dbg.KEY = 4'hF;
    dbg.SW = 10'h200;
    dbg.pc_fetch_unit = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({dbg.cpu_clk_en, dbg.sel_changed, dbg.busy, dbg.manual_mode} !== 4'b0001)
        $display("FAIL reset_state: {en,sel_changed,busy,manual}=%b, required 0001", {dbg.cpu_clk_en, dbg.sel_changed, dbg.busy, dbg.manual_mode});
      else passed++;
    end
    total++;
    if ({dbg.show_reg_mode, dbg.reg_sel, dbg.stage_sel} !== 9'd0)
      $display("FAIL reset_fields: {show,reg_sel,stage}=%b, required 0", {dbg.show_reg_mode, dbg.reg_sel, dbg.stage_sel});
    else passed++;
  endtask

  task automatic test_step();
    int e;
    exp_q.push_back(7);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (dbg.cpu_clk_en) begin
        total++;
        e = exp_q.size() ? exp_q.pop_front() : -1;
        if (k !== e || dbg.busy !== 1'b1) $display("FAIL step_enable: enable at +%0d busy=%b, required at +%0d busy=1", k, dbg.busy, e);
        else passed++;
      end
      if (k == 0) dbg.KEY[KEY_STEP] = 1'b0;
      if (k == 10) dbg.KEY[KEY_STEP] = 1'b1;
    end
    total++;
    if (exp_q.size() !== 0) $display("FAIL step_missing: %0d enables outstanding, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_bounce();
    int n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg.cpu_clk_en) begin
        total++;
        n++;
        $display("FAIL bounce_enable: enable at +%0d, required none", k);
      end
      dbg.KEY[KEY_STEP] = (k < 6) ? k[0] : 1'b1;
    end
    total++;
    if (n !== 0) $display("FAIL bounce_count: %0d enables, required 0", n);
    else passed++;
  endtask

  task automatic test_burst();
    int e;
    exp_q = '{7, 8, 9};
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (dbg.cpu_clk_en) begin
        total++;
        e = exp_q.size() ? exp_q.pop_front() : -1;
        if (k !== e || dbg.busy !== 1'b1) $display("FAIL burst_enable: enable at +%0d busy=%b, required at +%0d busy=1", k, dbg.busy, e);
        else passed++;
      end
      if (k == 12) begin
        total++;
        if (dbg.busy !== 1'b0) $display("FAIL burst_idle: busy=%b after burst, required 0", dbg.busy);
        else passed++;
      end
      if (k == 0) dbg.KEY[KEY_BURST] = 1'b0;
      if (k == 2) dbg.KEY[KEY_STEP] = 1'b0;
      if (k == 10) dbg.KEY[KEY_BURST] = 1'b1;
      if (k == 12) dbg.KEY[KEY_STEP] = 1'b1;
    end
    total++;
    if (exp_q.size() !== 0) $display("FAIL burst_missing: %0d enables outstanding, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_run();
    int e;
    for (int j = 7; j <= 29; j += 2) exp_q.push_back(j);
    sel_q = '{6, 18, 30};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dbg.cpu_clk_en) begin
        total++;
        e = exp_q.size() ? exp_q.pop_front() : -1;
        if (k !== e || dbg.busy !== 1'b0) $display("FAIL run_enable: enable at +%0d busy=%b, required at +%0d busy=0", k, dbg.busy, e);
        else passed++;
      end
      if (dbg.sel_changed) begin
        total++;
        e = sel_q.size() ? sel_q.pop_front() : -1;
        if (k !== e || dbg.reg_sel !== ((k >= 18) ? 5'd5 : 5'd0))
          $display("FAIL run_sel_changed: pulse at +%0d reg_sel=%0d, required at +%0d reg_sel=%0d", k, dbg.reg_sel, e, (k >= 18) ? 5 : 0);
        else passed++;
      end
      if (k == 0) dbg.SW = 10'h000;
      if (k == 12) dbg.SW = 10'h028;
      if (k == 24) dbg.SW = 10'h228;
    end
    total++;
    if (exp_q.size() + sel_q.size() !== 0) $display("FAIL run_missing: %0d enables and %0d strobes outstanding, required 0", exp_q.size(), sel_q.size());
    else passed++;
    exp_q.delete();
    sel_q.delete();
  endtask

`ifdef DEBUG_INPUT_BREAKPOINT_EN
  task automatic test_breakpoint();
    int e;
    exp_q = '{33, 35, 53};
    hit_q = '{37, 55};
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (dbg.cpu_clk_en) begin
        total++;
        e = exp_q.size() ? exp_q.pop_front() : -1;
        if (k !== e) $display("FAIL bp_enable: enable at +%0d, required at +%0d", k, e);
        else passed++;
      end
      if (dbg.bp_hit) begin
        total++;
        e = hit_q.size() ? hit_q.pop_front() : -1;
        if (k !== e) $display("FAIL bp_hit: pulse at +%0d, required at +%0d", k, e);
        else passed++;
      end
      if (k == 0) dbg.SW = 10'h20C;
      if (k == 8) dbg.KEY[KEY_BP] = 1'b0;
      if (k == 18) dbg.KEY[KEY_BP] = 1'b1;
      if (k == 26) dbg.SW = 10'h00C;
      if (k == 36) dbg.pc_fetch_unit = 7'd12;
      if (k == 46) dbg.KEY[KEY_STEP] = 1'b0;
      if (k == 56) dbg.KEY[KEY_STEP] = 1'b1;
    end
    total++;
    if (exp_q.size() + hit_q.size() !== 0) $display("FAIL bp_missing: %0d enables and %0d hits outstanding, required 0", exp_q.size(), hit_q.size());
    else passed++;
    exp_q.delete();
    hit_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_burst();
    test_run();
`ifdef DEBUG_INPUT_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
